bullet_ctrl: RTL and testbench

//  Player-side bullet generator: the driving end of the invaders' bullet/hit interface.

---
 rtl/game_pkg.sv | 34 +++
 rtl/fire_sync_edge.sv | 49 ++++
 rtl/bullet_ctrl.sv | 154 +++++++++++++++
 tb/tb_bullet_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared playfield geometry and bullet FSM state encoding for the game blocks.
//   COLS    : number of playfield columns
//   ROWS    : number of playfield rows
//   PARK_Y  : row value that means "no bullet on screen"
//   X_W/Y_W : widths of column and row coordinates
//   clamp_col() keeps a column index inside the playfield
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int COLS = 20;
  localparam int ROWS = 16;
  localparam int X_W  = 5;
  localparam int Y_W  = 4;

  localparam logic [Y_W-1:0] PARK_Y = 4'd0;

  typedef enum logic [1:0] {
    B_IDLE,
    B_FLYING,
    B_COOLDOWN
  } bullet_state_e;

  // Saturate a column index at the right-hand edge of the playfield.
  function automatic logic [X_W-1:0] clamp_col(input logic [X_W-1:0] x, input int cols);
    if (int'(x) > cols - 1) begin
      clamp_col = X_W'(cols - 1);
    end else begin
      clamp_col = x;
    end
  endfunction

endpackage

// File: rtl/fire_sync_edge.sv
// ---------------------------------------------------------------------------
// fire_sync_edge
// Brings an asynchronous push-button level into the clock domain through two
// flops and emits a one-cycle pulse on its rising edge.
// Ports:
//   i_clk_25MHz : system clock
//   i_reset_n   : synchronous reset, active low
//   i_async     : raw button level
//   o_rise      : one-cycle pulse, high on the cycle after ff2 first goes high
// ---------------------------------------------------------------------------
module fire_sync_edge (
  input  logic i_clk_25MHz,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic ff1_q;
  logic ff2_q;
  logic prev_q;
  logic vld1_q;
  logic vld2_q;
  logic armed_q;

  // Synchroniser chain plus the delayed copy used for edge detection.
  // vld1/vld2 track when ff2 starts carrying a real sample after reset; the
  // detector only arms once it has seen the button released, so a button
  // held down through reset release never produces a pulse.
  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset_n) begin
      ff1_q   <= 1'b0;
      ff2_q   <= 1'b0;
      prev_q  <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      ff1_q   <= i_async;
      ff2_q   <= ff1_q;
      prev_q  <= ff2_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      armed_q <= armed_q | (vld2_q & ~ff2_q);
    end
  end

  assign o_rise = ff2_q & ~prev_q & armed_q;

endmodule

// File: rtl/bullet_ctrl.sv
// ---------------------------------------------------------------------------
// bullet_ctrl
// Player-side bullet generator. A fire press launches one bullet from the
// player column; it climbs one row per step period and is retired on a hit
// from the invaders block or when it leaves the top row. After retirement a
// cooldown of COOLDOWN step periods must pass before another launch.
// Ports:
//   i_clk_25MHz     : system clock
//   i_reset_n       : synchronous reset, active low
//   i_fire          : fire button, asynchronous level
//   i_player_x      : current player column
//   i_hit           : registered hit pulse from the invaders block
//   o_bullet_x      : bullet column
//   o_bullet_y      : bullet row, 0 = no bullet
//   o_bullet_active : high while a bullet is flying
//   o_hits          : saturating hit counter
// ---------------------------------------------------------------------------
module bullet_ctrl
  import game_pkg::*;
#(
  parameter int SPEED    = 50000,
  parameter int COLS     = game_pkg::COLS,
  parameter int START_Y  = 14,
  parameter int COOLDOWN = 8
) (
  input  logic           i_clk_25MHz,
  input  logic           i_reset_n,
  input  logic           i_fire,
  input  logic [X_W-1:0] i_player_x,
  input  logic           i_hit,
  output logic [X_W-1:0] o_bullet_x,
  output logic [Y_W-1:0] o_bullet_y,
  output logic           o_bullet_active,
  output logic [7:0]     o_hits
);

  localparam int STEP_W = (SPEED > 1) ? $clog2(SPEED) : 1;
  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPEED - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN - 1);
  localparam logic [Y_W-1:0]    LAUNCH_Y  = Y_W'(START_Y);
  localparam logic [Y_W-1:0]    TOP_Y     = Y_W'(1);

  bullet_state_e     state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              active_q;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [7:0]        hits_q, hits_d;

  logic fire_rise;
  logic step_tick;

  fire_sync_edge u_fire_sync (
    .i_clk_25MHz (i_clk_25MHz),
    .i_reset_n   (i_reset_n),
    .i_async     (i_fire),
    .o_rise      (fire_rise)
  );

  assign step_tick = (step_q == STEP_LAST);

  // Next-state logic. The step counter free-runs in FLYING and COOLDOWN and
  // is cleared whenever a phase starts, so both the first bullet step and the
  // cooldown length are measured from the launch/retire edge. A hit takes
  // priority over a coincident step, so the bullet never shows the row above
  // the invader it struck.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    step_d  = step_tick ? '0 : step_q + 1'b1;
    cd_d    = cd_q;
    hits_d  = hits_q;

    case (state_q)
      B_IDLE: begin
        step_d = '0;
        cd_d   = '0;
        if (fire_rise) begin
          state_d = B_FLYING;
          x_d     = clamp_col(i_player_x, COLS);
          y_d     = LAUNCH_Y;
        end
      end

      B_FLYING: begin
        if (i_hit) begin
          hits_d  = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
          y_d     = PARK_Y;
          state_d = B_COOLDOWN;
          step_d  = '0;
          cd_d    = '0;
        end else if (step_tick) begin
          if (y_q == TOP_Y) begin
            y_d     = PARK_Y;
            state_d = B_COOLDOWN;
            cd_d    = '0;
          end else begin
            y_d = y_q - 1'b1;
          end
        end
      end

      B_COOLDOWN: begin
        if (step_tick) begin
          if (cd_q == CD_LAST) begin
            state_d = B_IDLE;
            cd_d    = '0;
          end else begin
            cd_d = cd_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = B_IDLE;
        y_d     = PARK_Y;
        step_d  = '0;
        cd_d    = '0;
      end
    endcase
  end

  // State and output registers. The active flag is derived from the next
  // state so it changes on the same edge as the state itself.
  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset_n) begin
      state_q  <= B_IDLE;
      x_q      <= '0;
      y_q      <= PARK_Y;
      active_q <= 1'b0;
      step_q   <= '0;
      cd_q     <= '0;
      hits_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= (state_d == B_FLYING);
      step_q   <= step_d;
      cd_q     <= cd_d;
      hits_q   <= hits_d;
    end
  end

  assign o_bullet_x      = x_q;
  assign o_bullet_y      = y_q;
  assign o_bullet_active = active_q;
  assign o_hits          = hits_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bullet_ctrl
// Self-checking bench for bullet_ctrl with SPEED=4, COOLDOWN=2. Expected
// output snapshots are queued as stimulus is applied and popped when the
// matching cycle is reached.
// ---------------------------------------------------------------------------
module tb_bullet_ctrl;

  localparam int SPEED    = 4;
  localparam int COOLDOWN = 2;
  localparam int START_Y  = 14;
  localparam int COLS     = 20;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    logic       act;
    logic [7:0] hits;
  } snap_t;

  logic       clk;
  logic       resetN;
  logic       fire;
  logic       hit;
  logic [4:0] playerX;
  logic [4:0] bulletX;
  logic [3:0] bulletY;
  logic       bulletActive;
  logic [7:0] hits;

  snap_t expQ[$];
  string tagQ[$];
  int    checks    = 0;
  int    errors    = 0;
  int    modelHits = 0;

  bullet_ctrl #(
    .SPEED    (SPEED),
    .COLS     (COLS),
    .START_Y  (START_Y),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .i_clk_25MHz     (clk),
    .i_reset_n       (resetN),
    .i_fire          (fire),
    .i_player_x      (playerX),
    .i_hit           (hit),
    .o_bullet_x      (bulletX),
    .o_bullet_y      (bulletY),
    .o_bullet_active (bulletActive),
    .o_hits          (hits)
  );

  // 25 MHz clock.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Advance n clock edges, then settle just past the edge before sampling.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the snapshot the DUT should show at the next comparison point.
  task automatic pushExpect(input string t, input int x, input int y, input int act, input int h);
    snap_t s;
    s.x    = 5'(x);
    s.y    = 4'(y);
    s.act  = 1'(act);
    s.hits = 8'(h);
    expQ.push_back(s);
    tagQ.push_back(t);
  endtask

  // Hold reset for a couple of edges with the button released, then give the
  // fire synchroniser time to arm.
  task automatic doReset();
    resetN = 1'b0;
    fire   = 1'b0;
    hit    = 1'b0;
    cyc(2);
    resetN    = 1'b1;
    modelHits = 0;
    cyc(4);
  endtask

  // Reset values, and a button held through reset release must not launch.
  task automatic test_reset();
    snap_t e, o;
    string t;
    resetN  = 1'b0;
    fire    = 1'b1;
    hit     = 1'b0;
    playerX = 5'd3;
    pushExpect("reset_zero", 0, 0, 0, 0);
    cyc(3);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    resetN = 1'b1;
    pushExpect("held_fire_no_launch", 0, 0, 0, 0);
    cyc(10);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    fire = 1'b0;
    cyc(4);
    fire = 1'b1;
    pushExpect("launch_after_release", 3, START_Y, 1, 0);
    cyc(3);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    fire = 1'b0;
  endtask

  // Launch latency, first step timing, and a full climb to a miss.
  task automatic test_launch_miss();
    snap_t e, o;
    string t;
    doReset();
    playerX = 5'd7;
    fire    = 1'b1;
    pushExpect("pre_launch", 0, 0, 0, 0);
    cyc(2);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    pushExpect("launch", 7, START_Y, 1, 0);
    cyc(1);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    fire    = 1'b0;
    playerX = 5'd0;
    pushExpect("hold_before_step", 7, START_Y, 1, 0);
    cyc(SPEED - 1);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    pushExpect("first_step", 7, START_Y - 1, 1, 0);
    cyc(1);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    pushExpect("top_row", 7, 1, 1, 0);
    cyc(14 * SPEED - SPEED - 1);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    pushExpect("miss_retire", 7, 0, 0, 0);
    cyc(1);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
  endtask

  // A hit coinciding with a step wins; a later hit during cooldown is stale.
  task automatic test_hit_with_step();
    snap_t e, o;
    string t;
    doReset();
    playerX = 5'd2;
    fire    = 1'b1;
    cyc(3);
    fire = 1'b0;
    pushExpect("at_y5", 2, 5, 1, 0);
    cyc(9 * SPEED);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    cyc(SPEED - 1);
    hit = 1'b1;
    modelHits++;
    pushExpect("hit_beats_step", 2, 0, 0, modelHits);
    cyc(1);
    hit = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    hit = 1'b1;
    pushExpect("stale_hit_in_cooldown", 2, 0, 0, modelHits);
    cyc(1);
    hit = 1'b0;
    cyc(2);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
  endtask

  // Fire presses in flight and during cooldown are dropped; the cooldown
  // lasts exactly SPEED*COOLDOWN cycles.
  task automatic test_ignore_fire();
    snap_t e, o;
    string t;
    doReset();
    playerX = 5'd4;
    fire    = 1'b1;
    cyc(3);
    fire = 1'b0;
    cyc(5);
    fire = 1'b1;
    pushExpect("fire_in_flight", 4, START_Y - 2, 1, 0);
    cyc(3);
    fire = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    cyc(2);
    hit = 1'b1;
    modelHits++;
    pushExpect("retire_on_hit", 4, 0, 0, modelHits);
    cyc(1);
    hit = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    fire = 1'b1;
    pushExpect("fire_in_cooldown", 4, 0, 0, modelHits);
    cyc(3);
    fire = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    cyc(2);
    fire = 1'b1;
    pushExpect("fire_on_last_cooldown_edge", 4, 0, 0, modelHits);
    cyc(3);
    fire = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    cyc(1);
    playerX = 5'd9;
    fire    = 1'b1;
    pushExpect("fire_after_cooldown", 9, START_Y, 1, modelHits);
    cyc(3);
    fire = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
  endtask

  // Hits while idle do not count; an out-of-range column is clamped.
  task automatic test_clamp_idle_hit();
    snap_t e, o;
    string t;
    doReset();
    hit = 1'b1;
    cyc(2);
    hit = 1'b0;
    pushExpect("idle_hit_ignored", 0, 0, 0, 0);
    cyc(1);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    playerX = 5'd25;
    fire    = 1'b1;
    pushExpect("clamp_x25", COLS - 1, START_Y, 1, 0);
    cyc(3);
    fire = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
  endtask

  // Back-to-back launch/hit cycles drive the counter to saturation.
  task automatic test_back_to_back();
    snap_t e, o;
    string t;
    doReset();
    for (int i = 0; i < 256; i++) begin
      playerX = 5'(i % COLS);
      fire    = 1'b1;
      cyc(3);
      fire = 1'b0;
      hit  = 1'b1;
      if (modelHits < 255) modelHits++;
      pushExpect("hit_count", i % COLS, 0, 0, modelHits);
      cyc(1);
      hit = 1'b0;
      e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL %s[%0d]: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, i, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
      cyc(6);
    end
  endtask

  // Reset during flight clears everything at the next edge, hits included.
  task automatic test_reset_midflight();
    snap_t e, o;
    string t;
    playerX = 5'd5;
    fire    = 1'b1;
    pushExpect("launch_saturated", 5, START_Y, 1, modelHits);
    cyc(3);
    fire = 1'b0;
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    cyc(6);
    resetN    = 1'b0;
    modelHits = 0;
    pushExpect("reset_midflight", 0, 0, 0, 0);
    cyc(1);
    e = expQ.pop_front(); t = tagQ.pop_front(); o = {bulletX, bulletY, bulletActive, hits}; checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b hits=%0d, want x=%0d y=%0d act=%0b hits=%0d", t, o.x, o.y, o.act, o.hits, e.x, e.y, e.act, e.hits); end
    resetN = 1'b1;
  endtask

  // Run every scenario in order, then report.
  initial begin
    resetN  = 1'b0;
    fire    = 1'b0;
    hit     = 1'b0;
    playerX = '0;
    $display("[TB] starting bullet_ctrl bench");
    test_reset();
    test_launch_miss();
    test_hit_with_step();
    test_ignore_fire();
    test_clamp_idle_hit();
    test_back_to_back();
    test_reset_midflight();
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #4000000;
    $display("[TB] FAIL timeout: got no completion, want finish before time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
